// File: rtl/uart_debug_bridge.sv
// uart_debug_bridge: byte-stream command engine that drives single AHB-Lite
// transfers (read / write / alive / error reply) from a UART byte interface.
// Byte streams: a byte moves on rx when rx_valid && rx_ready, and on tx when
// tx_valid && tx_ready; tx_data/tx_valid hold steady until accepted.
module uart_debug_bridge #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter bit          AUTO_INC   = 1'b1,
  parameter logic [15:0] ALIVE_CODE = 16'h00AE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  output logic              busy,
  output logic              cmd_err,
  output logic [3:0]        o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_CNT, S_GET_ADDR, S_GET_WDATA, S_AHB_ADDR,
    S_AHB_DATA, S_SEND_RD, S_SEND_ALIVE, S_SEND_ERR
  } state_t;

  localparam int                A_BYTES   = ADDR_W / 8;
  localparam int                D_BYTES   = DATA_W / 8;
  localparam logic [1:0]        A_LAST    = 2'(A_BYTES - 1);
  localparam logic [1:0]        D_LAST    = 2'(D_BYTES - 1);
  localparam logic [2:0]        HSIZE_C   = (DATA_W == 8) ? 3'd0 : (DATA_W == 16) ? 3'd1 : 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(D_BYTES);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_count;
  logic [7:0]        r_rem;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_idx;
  logic              r_write;
  logic              r_cmd_err;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_bus_err;

  assign w_rx_fire = rx_valid && rx_ready;
  assign w_tx_fire = tx_valid && tx_ready;
  assign w_bus_err = (HRESP == 2'b01);

  assign HADDR       = r_addr;
  assign HWDATA      = r_data;
  assign HSIZE       = HSIZE_C;
  assign HBURST      = 3'b000;
  assign cmd_err     = r_cmd_err;
  assign o_dbg_state = r_state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and per-state outputs
  always_comb begin
    w_next   = r_state;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    HTRANS   = 2'b00;
    HWRITE   = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        rx_ready = !rst;
        if (w_rx_fire) begin
          case (rx_data)
            8'h82:   w_next = S_GET_CNT;
            8'h83:   w_next = S_GET_ADDR;
            8'h84:   w_next = (r_count == 8'd0) ? S_IDLE : S_AHB_ADDR;
            8'h85:   w_next = (r_count == 8'd0) ? S_IDLE : S_GET_WDATA;
            8'h86:   w_next = S_SEND_ALIVE;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_GET_CNT: begin
        rx_ready = !rst;
        if (w_rx_fire) w_next = S_IDLE;
      end
      S_GET_ADDR: begin
        rx_ready = !rst;
        if (w_rx_fire && r_idx == A_LAST) w_next = S_IDLE;
      end
      S_GET_WDATA: begin
        rx_ready = !rst;
        if (w_rx_fire && r_idx == D_LAST) w_next = S_AHB_ADDR;
      end
      S_AHB_ADDR: begin
        HTRANS = 2'b10;
        HWRITE = r_write;
        if (HREADY) w_next = S_AHB_DATA;
      end
      S_AHB_DATA: begin
        if (HREADY) begin
          if (w_bus_err)         w_next = S_SEND_ERR;
          else if (!r_write)     w_next = S_SEND_RD;
          else if (r_rem == 8'd1) w_next = S_IDLE;
          else                   w_next = S_GET_WDATA;
        end
      end
      S_SEND_RD: begin
        tx_valid = !rst;
        tx_data  = r_data[DATA_W-1 -: 8];
        if (w_tx_fire && r_idx == D_LAST) w_next = (r_rem == 8'd0) ? S_IDLE : S_AHB_ADDR;
      end
      S_SEND_ALIVE: begin
        tx_valid = !rst;
        tx_data  = (r_idx == 2'd0) ? ALIVE_CODE[15:8] : ALIVE_CODE[7:0];
        if (w_tx_fire && r_idx == 2'd1) w_next = S_IDLE;
      end
      S_SEND_ERR: begin
        tx_valid = !rst;
        tx_data  = 8'hEE;
        if (w_tx_fire) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: count/address/data registers, byte index and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 8'd1;
      r_rem     <= 8'd0;
      r_addr    <= '0;
      r_data    <= '0;
      r_idx     <= 2'd0;
      r_write   <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_idx <= 2'd0;
            case (rx_data)
              8'h82, 8'h83, 8'h86: ;
              8'h84: begin r_write <= 1'b0; r_rem <= r_count; end
              8'h85: begin r_write <= 1'b1; r_rem <= r_count; end
              default: r_cmd_err <= 1'b1;
            endcase
          end
        end
        S_GET_CNT: if (w_rx_fire) r_count <= rx_data;
        S_GET_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= ADDR_W'({r_addr, rx_data});
            r_idx  <= r_idx + 2'd1;
          end
        end
        S_GET_WDATA: begin
          if (w_rx_fire) begin
            r_data <= DATA_W'({r_data, rx_data});
            r_idx  <= (r_idx == D_LAST) ? 2'd0 : r_idx + 2'd1;
          end
        end
        S_AHB_DATA: begin
          // A failed transfer leaves the address where it was.
          if (HREADY && !w_bus_err) begin
            if (AUTO_INC) r_addr <= r_addr + ADDR_STEP;
            r_rem <= r_rem - 8'd1;
            r_idx <= 2'd0;
            if (!r_write) r_data <= HRDATA;
          end
        end
        S_SEND_RD: begin
          if (w_tx_fire) begin
            r_data <= DATA_W'({r_data, 8'h00}) ;
            r_idx  <= (r_idx == D_LAST) ? 2'd0 : r_idx + 2'd1;
          end
        end
        S_SEND_ALIVE: if (w_tx_fire) r_idx <= r_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Directed bench for uart_debug_bridge with a small AHB slave memory model.
module tb_uart_debug_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        busy;
  logic        cmd_err;
  logic [3:0]  dbg_state;

  uart_debug_bridge dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .busy(busy), .cmd_err(cmd_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard queues
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [32:0] exp_bus_q[$];
  logic [32:0] bus_q[$];

  // slave model state
  logic [31:0] mem [0:63];
  int          waits  = 0;
  int          err_at = -1;
  int          xfer_n = 0;
  int          wcnt   = 0;
  logic        sl_data = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        pend_write = 1'b0;
  logic        tx_toggle = 1'b0;

  // AHB slave: observe at negedge, drive responses just after posedge
  initial begin
    logic        done_data, got_addr, a_stall, d_stall;
    logic [33:0] a_prev;
    logic [31:0] d_prev;
    a_stall = 1'b0; d_stall = 1'b0; a_prev = '0; d_prev = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    forever begin
      @(negedge clk);
      if (a_stall) check("haddr_hold", {HTRANS, HADDR}, a_prev);
      if (d_stall) check("hwdata_hold", HWDATA, d_prev);
      a_stall = (HTRANS == 2'b10) && !HREADY;
      a_prev  = {HTRANS, HADDR};
      d_stall = sl_data && pend_write && !HREADY;
      d_prev  = HWDATA;
      done_data = 1'b0; got_addr = 1'b0;
      if (HREADY && sl_data) begin
        done_data = 1'b1;
        if (pend_write && HRESP != 2'b01) mem[pend_addr[7:2]] = HWDATA;
      end
      if (HREADY && HTRANS == 2'b10) begin
        got_addr   = 1'b1;
        pend_addr  = HADDR;
        pend_write = HWRITE;
        xfer_n++;
        bus_q.push_back({HWRITE, HADDR});
      end
      @(posedge clk); #1;
      if (done_data || got_addr) wcnt = 0;
      if (done_data) sl_data = 1'b0;
      if (got_addr)  sl_data = 1'b1;
      if (sl_data || HTRANS == 2'b10) begin
        if (wcnt < waits) begin HREADY = 1'b0; wcnt++; end
        else HREADY = 1'b1;
      end else HREADY = 1'b1;
      HRDATA = (sl_data && !pend_write) ? mem[pend_addr[7:2]] : 32'h0;
      HRESP  = (sl_data && xfer_n == err_at) ? 2'b01 : 2'b00;
    end
  end

  // tx_ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = tx_toggle ? ~tx_ready : 1'b1;
    end
  end

  // tx monitor with hold-stability check
  initial begin
    logic       stall;
    logic [7:0] prev;
    stall = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("tx_valid_hold", tx_valid, 1'b1);
        check("tx_data_hold", tx_data, prev);
      end
      stall = tx_valid && !tx_ready;
      prev  = tx_data;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data = b; rx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (!ok) check("rx_accept_timeout", ok, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic set_addr(input logic [31:0] a);
    send_byte(8'h83); send_word(a);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("idle_timeout", ok, 1'b1);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic cmp_tx(input string tag);
    check({tag, "_txlen"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_tx"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete(); exp_q.delete();
  endtask

  task automatic cmp_bus(input string tag);
    check({tag, "_buslen"}, bus_q.size(), exp_bus_q.size());
    while (bus_q.size() > 0 && exp_bus_q.size() > 0) check({tag, "_bus"}, bus_q.pop_front(), exp_bus_q.pop_front());
    bus_q.delete(); exp_bus_q.delete();
  endtask

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // main sequence
  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_state", dbg_state, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // alive x3
    repeat (3) send_byte(8'h86);
    wait_idle();
    repeat (3) begin exp_q.push_back(8'h00); exp_q.push_back(8'hAE); end
    cmp_tx("alive");
    cmp_bus("alive");
    check("alive_busy", busy, 1'b0);

    // single write
    send_byte(8'h82); send_byte(8'h01);
    set_addr(32'h10);
    send_byte(8'h85); send_word(32'hDEADBEEF);
    wait_idle();
    exp_bus_q.push_back({1'b1, 32'h10});
    cmp_bus("wr1");
    check("wr1_mem", mem[4], 32'hDEADBEEF);
    check("wr1_haddr", HADDR, 32'h14);
    check("hsize", HSIZE, 3'b010);
    check("hburst", HBURST, 3'b000);

    // three writes then three reads
    send_byte(8'h82); send_byte(8'h03);
    set_addr(32'h0);
    send_byte(8'h85); send_word(32'h0); send_word(32'h1); send_word(32'h2);
    wait_idle();
    set_addr(32'h0);
    send_byte(8'h84);
    wait_idle();
    exp_bus_q.push_back({1'b1, 32'h0}); exp_bus_q.push_back({1'b1, 32'h4}); exp_bus_q.push_back({1'b1, 32'h8});
    exp_bus_q.push_back({1'b0, 32'h0}); exp_bus_q.push_back({1'b0, 32'h4}); exp_bus_q.push_back({1'b0, 32'h8});
    cmp_bus("wr3rd3");
    push_word(32'h0); push_word(32'h1); push_word(32'h2);
    cmp_tx("rd3");
    check("rd3_haddr", HADDR, 32'hC);

    // wait states and tx back-pressure
    waits = 2; tx_toggle = 1'b1;
    send_byte(8'h82); send_byte(8'h02);
    set_addr(32'h20);
    send_byte(8'h85); send_word(32'h11223344); send_word(32'h55667788);
    wait_idle();
    set_addr(32'h20);
    send_byte(8'h84);
    wait_idle();
    exp_bus_q.push_back({1'b1, 32'h20}); exp_bus_q.push_back({1'b1, 32'h24});
    exp_bus_q.push_back({1'b0, 32'h20}); exp_bus_q.push_back({1'b0, 32'h24});
    cmp_bus("stall");
    push_word(32'h11223344); push_word(32'h55667788);
    cmp_tx("stall");
    check("stall_mem", mem[9], 32'h55667788);
    waits = 0; tx_toggle = 1'b0;

    // bus error on second of four reads
    send_byte(8'h82); send_byte(8'h04);
    set_addr(32'h20);
    err_at = xfer_n + 2;
    send_byte(8'h84);
    wait_idle();
    err_at = -1;
    exp_bus_q.push_back({1'b0, 32'h20}); exp_bus_q.push_back({1'b0, 32'h24});
    cmp_bus("err");
    push_word(32'h11223344); exp_q.push_back(8'hEE);
    cmp_tx("err");
    check("err_haddr", HADDR, 32'h24);
    check("err_state", dbg_state, 4'd0);

    // count of zero: no bus cycle, no bytes
    send_byte(8'h82); send_byte(8'h00);
    send_byte(8'h84);
    send_byte(8'h85);
    wait_idle();
    cmp_bus("n0");
    cmp_tx("n0");
    check("n0_busy", busy, 1'b0);

    // illegal byte sets sticky cmd_err
    send_byte(8'h41);
    @(negedge clk);
    check("cmd_err_set", cmd_err, 1'b1);
    @(posedge clk); #1;
    send_byte(8'h86);
    wait_idle();
    exp_q.push_back(8'h00); exp_q.push_back(8'hAE);
    cmp_tx("err_alive");
    check("cmd_err_sticky", cmd_err, 1'b1);

    // reset in the middle of a write
    send_byte(8'h82); send_byte(8'h04);
    send_byte(8'h85); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rx_ready", rx_ready, 1'b0);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_cmd_err", cmd_err, 1'b0);
    check("post_rst_haddr", HADDR, 32'h0);
    check("post_rst_hwdata", HWDATA, 32'h0);
    check("post_rst_htrans", HTRANS, 2'b00);
    check("post_rst_hwrite", HWRITE, 1'b0);
    check("post_rst_tx_data", tx_data, 8'h00);
    repeat (10) @(negedge clk);
    cmp_bus("mid_rst");
    @(posedge clk); #1;
    // count is back to 1 and address back to 0
    send_byte(8'h84);
    wait_idle();
    exp_bus_q.push_back({1'b0, 32'h0});
    cmp_bus("post_rst_rd");
    push_word(32'h0);
    cmp_tx("post_rst_rd");
    check("post_rst_rd_haddr", HADDR, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_debug_bridge.md
# uart_debug_bridge

Parametrised UART-debugger command engine that turns a host byte stream into AHB-Lite master transfers and returns read data and status bytes. It sits between the UART receiver/transmitter byte interfaces and the system AHB bus. It generalises the fixed 32-bit debugger in address width, data width and address auto-increment, and adds bus-error reporting and back-pressure on both byte streams.

## Interface
- ADDR_W, 32: AHB address width; multiple of 8, range 8..32.
- DATA_W, 32: transfer width; 8, 16 or 32. HSIZE = log2(DATA_W/8).
- AUTO_INC, 1: 1 = address advances by DATA_W/8 after every completed transfer; 0 = address is fixed.
- ALIVE_CODE, 16'h00AE: two-byte reply to the alive command, sent MSB first.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  bridge accepts a byte this cycle.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data.
- HADDR  out  ADDR_W  AHB address.
- HWRITE  out  1  1 = write.
- HSIZE  out  3  fixed from DATA_W.
- HBURST  out  3  always 3'b000 (SINGLE).
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
- HWDATA  out  DATA_W  write data, driven during the data phase.
- HRDATA  in  DATA_W  read data.
- HREADY  in  1  transfer complete / bus ready.
- HRESP  in  2  2'b01 = ERROR; all other values = OKAY.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  sticky flag for an illegal byte received in IDLE; cleared only by rst.

## Operation
- A byte is transferred on rx when rx_valid and rx_ready are both high, and on tx when tx_valid and tx_ready are both high.
- Command bytes have bit 7 set:
  - 0x82 SET_COUNT: next byte is the count N, 0..255.
  - 0x83 SET_ADDR: next ADDR_W/8 bytes are the address, MSB first.
  - 0x84 READ: perform N reads.
  - 0x85 WRITE: perform N writes.
  - 0x86 ALIVE: send ALIVE_CODE.
- In IDLE, any other byte (unknown command, or bit 7 clear) is consumed, discarded, and sets cmd_err.
- State machine states: IDLE, GET_CNT, GET_ADDR, GET_WDATA, AHB_ADDR, AHB_DATA, SEND_RD, SEND_ALIVE, SEND_ERR.
- Registers:
  - count reg resets to 1.
  - addr reg resets to 0.
  - A working counter rem is loaded from count at READ/WRITE, so count itself persists across commands.
- WRITE: loop of GET_WDATA (DATA_W/8 bytes, MSB first) -> AHB_ADDR -> AHB_DATA, repeated until rem = 0, then IDLE.
- READ: loop of AHB_ADDR -> AHB_DATA (capture HRDATA) -> SEND_RD (DATA_W/8 bytes, MSB first), repeated until rem = 0, then IDLE.
- N = 0: READ/WRITE returns straight to IDLE, with no bus cycle and no bytes consumed or sent.
- Address update: when AUTO_INC = 1, addr += DATA_W/8 after each OKAY transfer, modulo 2^ADDR_W (wraps to 0). The updated address persists into later commands.
- Bus error: HRESP = ERROR in the data phase aborts the remaining transfers. The engine goes to SEND_ERR, emits one byte 0xEE, then returns to IDLE. addr is not incremented for the failed transfer.
- rx_ready is high only in IDLE, GET_CNT, GET_ADDR and GET_WDATA. tx_valid is high only in SEND_RD, SEND_ALIVE and SEND_ERR.

## Timing
- Reset (rst sampled high) sets:
  - state IDLE, HTRANS 00, HWRITE 0, HADDR 0, HWDATA 0.
  - tx_valid 0, tx_data 0, rx_ready 0 in the reset cycle.
  - busy 0, cmd_err 0, count 1, addr 0.
- rst mid-command drops any partial bytes or transfers; rst has priority over all other inputs.
- AHB_ADDR:
  - HTRANS = NONSEQ with HADDR/HWRITE valid.
  - Holds while HREADY = 0.
  - Moves to AHB_DATA on the edge where HREADY = 1.
- AHB_DATA:
  - HTRANS = IDLE; HWDATA is held stable.
  - Completes on the first edge with HREADY = 1; HRDATA and HRESP are sampled on that edge.
- Write latency: NONSEQ is driven in the cycle after the last data byte is accepted.
- Read latency: the first tx byte is valid in the cycle after data-phase completion.
- tx_data/tx_valid stay stable until tx_ready; with tx_ready held high, one byte goes out per cycle.
- If rx_valid is asserted while rx_ready = 0, the byte is not consumed; the upstream source must hold it.

## Test plan
- Reset, then ALIVE (0x86) three times with tx_ready = 1 -> tx emits 00 AE 00 AE 00 AE; no AHB activity; busy low afterwards.
- SET_COUNT 1, SET_ADDR 0x00000010, WRITE with data 0xDEADBEEF -> one NONSEQ write at HADDR 0x10, HWDATA 0xDEADBEEF, HSIZE 010; addr becomes 0x14.
- SET_COUNT 3, SET_ADDR 0x0, WRITE words 0, 1, 2, then SET_ADDR 0x0, READ -> writes at 0x0, 0x4, 0x8; tx emits 00 00 00 00 00 00 00 01 00 00 00 02.
- Slave inserts 2 wait states in every phase and tx_ready toggles -> HADDR, HWDATA and tx_data stay stable while stalled; data is still correct.
- READ with N = 4 where the slave returns ERROR on transfer 2 -> only the first read is returned, then 0xEE; addr has advanced by exactly 4; state returns to IDLE.
- Byte 0x41 in IDLE -> cmd_err = 1 and stays set; rst asserted mid-WRITE after 2 of 4 data bytes -> all outputs return to reset values and no NONSEQ is issued.
